// File: rtl/hamming_dec_engine.sv
// hamming_dec_engine
// Memory-walking SECDED Hamming(16,11) decoder. Reads NUM_WORDS encoded words
// (two bytes each) from the shared byte-wide data memory. For each word it
// corrects a single-bit error, flags a double-bit error, and writes the 11-bit
// message plus a 2-bit status back to the output region.
//
// Encoded word bits [15:0] = {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}.
// Result high byte = {flags, 3'b000, d11..d9}; result low byte = d8..d1.
// Flags: 00 clean, 01 single error (corrected), 10 double error (raw data).

module hamming_dec_engine #(
   parameter int NUM_WORDS = 15,
   parameter int IN_BASE   = 30,
   parameter int OUT_BASE  = 0,
   parameter int ADDR_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rd_data,
   output logic              mem_wr_en,
   output logic [7:0]        mem_wr_data,
   output logic [3:0]        err1_cnt,
   output logic [3:0]        err2_cnt,
   output logic              done
);

   localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   localparam logic [ADDR_W-1:0] IN_BASE_A  = ADDR_W'(IN_BASE);
   localparam logic [ADDR_W-1:0] OUT_BASE_A = ADDR_W'(OUT_BASE);
   localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_WORDS - 1);

   typedef enum logic [2:0] {
      IDLE,
      RD_LO,
      RD_HI,
      CAP_HI,
      DEC,
      WR_LO,
      WR_HI,
      DONE
   } state_t;

   state_t state_reg;

   logic [IDX_W-1:0] idx_reg;
   logic [15:0]      word_reg;     // encoded word being decoded
   logic [7:0]       hi_byte_reg;  // result high byte, held for the WR_HI beat

   // Hamming position of message bit j (d1 is j=0); powers of two hold parity.
   function automatic int data_pos(input int j);
      if (j == 0)
         return 3;
      else if (j <= 3)
         return j + 4;
      else
         return j + 5;
   endfunction

   // ------------------------------------------------------------------
   // Address generation for the current and the following word
   // ------------------------------------------------------------------
   logic [IDX_W-1:0]  idx_inc;
   logic [ADDR_W-1:0] word_off;
   logic [ADDR_W-1:0] next_off;
   logic [ADDR_W-1:0] in_hi_addr;
   logic [ADDR_W-1:0] out_lo_addr;
   logic [ADDR_W-1:0] out_hi_addr;
   logic [ADDR_W-1:0] next_in_lo_addr;

   assign idx_inc         = idx_reg + IDX_W'(1);
   assign word_off        = ADDR_W'({idx_reg, 1'b0});
   assign next_off        = ADDR_W'({idx_inc, 1'b0});
   assign in_hi_addr      = IN_BASE_A + word_off + ADDR_W'(1);
   assign out_lo_addr     = OUT_BASE_A + word_off;
   assign out_hi_addr     = OUT_BASE_A + word_off + ADDR_W'(1);
   assign next_in_lo_addr = IN_BASE_A + next_off;

   // ------------------------------------------------------------------
   // Syndrome: XOR of the position indices of all set bits 1..15
   // ------------------------------------------------------------------
   logic [3:0] syn_term [1:15];
   logic [3:0] syndrome;
   logic       overall_par;

   generate
      for (genvar gi = 1; gi < 16; gi++) begin : g_syn
         assign syn_term[gi] = word_reg[gi] ? 4'(gi) : 4'd0;
      end
   endgenerate

   // Fold the per-bit index contributions into the syndrome
   always_comb begin
      syndrome = 4'd0;
      for (int k = 1; k < 16; k++) begin
         syndrome = syndrome ^ syn_term[k];
      end
   end

   assign overall_par = ^word_reg;

   // ------------------------------------------------------------------
   // Message extraction with single-error correction. A bit is flipped
   // only when overall parity is odd and the syndrome points at it; an
   // error in p0 (syndrome 0) leaves the message untouched, and a double
   // error (even parity, nonzero syndrome) passes the data through raw.
   // ------------------------------------------------------------------
   logic [10:0] dec_data;

   generate
      for (genvar gi = 0; gi < 11; gi++) begin : g_data
         localparam int POS = data_pos(gi);
         assign dec_data[gi] = word_reg[POS] ^ (overall_par && (syndrome == 4'(POS)));
      end
   endgenerate

   // Classify the word into its status flags
   logic [1:0] dec_flags;

   always_comb begin
      dec_flags = 2'b00;
      if (overall_par)
         dec_flags = 2'b01;
      else if (syndrome != 4'd0)
         dec_flags = 2'b10;
   end

   // ------------------------------------------------------------------
   // Control FSM; every memory-side output is registered on the edge that
   // enters the state in which it must be valid.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         idx_reg     <= '0;
         word_reg    <= '0;
         hi_byte_reg <= '0;
         mem_addr    <= '0;
         mem_wr_en   <= 1'b0;
         mem_wr_data <= '0;
         err1_cnt    <= 4'd0;
         err2_cnt    <= 4'd0;
         done        <= 1'b0;
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               if (start) begin
                  state_reg <= RD_LO;
                  idx_reg   <= '0;
                  err1_cnt  <= 4'd0;
                  err2_cnt  <= 4'd0;
                  done      <= 1'b0;
                  mem_addr  <= IN_BASE_A;
                  mem_wr_en <= 1'b0;
               end
            end

            RD_LO: begin
               // Low-byte address is on the bus; move on to the high byte
               mem_addr  <= in_hi_addr;
               state_reg <= RD_HI;
            end

            RD_HI: begin
               word_reg[7:0] <= mem_rd_data;
               state_reg     <= CAP_HI;
            end

            CAP_HI: begin
               word_reg[15:8] <= mem_rd_data;
               state_reg      <= DEC;
            end

            DEC: begin
               hi_byte_reg <= {dec_flags, 3'b000, dec_data[10:8]};
               mem_wr_data <= dec_data[7:0];
               mem_addr    <= out_lo_addr;
               mem_wr_en   <= 1'b1;
               if (dec_flags == 2'b01 && err1_cnt != 4'd15)
                  err1_cnt <= err1_cnt + 4'd1;
               if (dec_flags == 2'b10 && err2_cnt != 4'd15)
                  err2_cnt <= err2_cnt + 4'd1;
               state_reg <= WR_LO;
            end

            WR_LO: begin
               mem_wr_data <= hi_byte_reg;
               mem_addr    <= out_hi_addr;
               state_reg   <= WR_HI;
            end

            WR_HI: begin
               mem_wr_en <= 1'b0;
               if (idx_reg == LAST_IDX) begin
                  done      <= 1'b1;
                  state_reg <= DONE;
               end else begin
                  idx_reg   <= idx_inc;
                  mem_addr  <= next_in_lo_addr;
                  state_reg <= RD_LO;
               end
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hamming_dec_engine.sv
// tb_hamming_dec_engine
// Drives whole decode runs against a behavioural byte memory. Expected writes
// (cycle, address, byte) are queued when a run is loaded and popped as the
// engine writes them.

module tb_hamming_dec_engine;

   localparam int NW       = 15;
   localparam int IN_BASE  = 30;
   localparam int OUT_BASE = 0;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] mem_addr;
   logic [7:0] mem_rd_data;
   logic       mem_wr_en;
   logic [7:0] mem_wr_data;
   logic [3:0] err1_cnt;
   logic [3:0] err2_cnt;
   logic       done;

   hamming_dec_engine #(
      .NUM_WORDS (NW),
      .IN_BASE   (IN_BASE),
      .OUT_BASE  (OUT_BASE),
      .ADDR_W    (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .mem_addr    (mem_addr),
      .mem_rd_data (mem_rd_data),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_data (mem_wr_data),
      .err1_cnt    (err1_cnt),
      .err2_cnt    (err2_cnt),
      .done        (done)
   );

   always #5 clk = ~clk;

   // Byte memory: input image written only by the stimulus, output image
   // written only by the engine; one-cycle registered read.
   logic [7:0] in_mem  [256];
   logic [7:0] out_mem [256];

   always @(posedge clk) begin
      mem_rd_data <= in_mem[mem_addr];
      if (mem_wr_en)
         out_mem[mem_addr] <= mem_wr_data;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic bit is_parity_pos(input int k);
      return (k == 1) || (k == 2) || (k == 4) || (k == 8);
   endfunction

   // Reference encoder: place message bits, then solve parity so syndrome is 0
   function automatic logic [15:0] encode(input logic [10:0] d);
      logic [15:0] c = 16'h0000;
      logic [3:0]  s = 4'd0;
      int          j = 0;
      for (int k = 1; k < 16; k++) begin
         if (!is_parity_pos(k)) begin
            c[k] = d[j];
            j++;
         end
      end
      for (int k = 1; k < 16; k++)
         if (c[k]) s = s ^ 4'(k);
      c[1] = s[0];
      c[2] = s[1];
      c[4] = s[2];
      c[8] = s[3];
      c[0] = ^c[15:1];
      return c;
   endfunction

   // Reference decoder: returns {high byte, low byte}
   function automatic logic [15:0] model_dec(input logic [15:0] w_in);
      logic [15:0] w = w_in;
      logic [3:0]  s = 4'd0;
      logic        p = 1'b0;
      logic [1:0]  f;
      logic [10:0] d = 11'd0;
      int          j = 0;
      for (int k = 0; k < 16; k++) begin
         if (w[k]) begin
            p = ~p;
            s = s ^ 4'(k);
         end
      end
      if (p) begin
         f = 2'b01;
         if (s != 4'd0) w[s] = ~w[s];
      end else if (s != 4'd0) begin
         f = 2'b10;
      end else begin
         f = 2'b00;
      end
      for (int k = 1; k < 16; k++) begin
         if (!is_parity_pos(k)) begin
            d[j] = w[k];
            j++;
         end
      end
      return {f, 3'b000, d[10:8], d[7:0]};
   endfunction

   typedef struct {
      int         cyc;
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t         exp_q [$];
   logic [15:0] words [NW];
   int          exp_e1;
   int          exp_e2;

   // Place words[] in the input region and queue the expected writes
   task automatic load_run();
      logic [15:0] r;
      exp_q.delete();
      exp_e1 = 0;
      exp_e2 = 0;
      for (int i = 0; i < NW; i++) begin
         in_mem[IN_BASE + 2*i]     = words[i][7:0];
         in_mem[IN_BASE + 2*i + 1] = words[i][15:8];
         r = model_dec(words[i]);
         exp_q.push_back('{5 + 6*i, 8'(OUT_BASE + 2*i), r[7:0]});
         exp_q.push_back('{6 + 6*i, 8'(OUT_BASE + 2*i + 1), r[15:8]});
         if (r[15:14] == 2'b01 && exp_e1 < 15) exp_e1++;
         if (r[15:14] == 2'b10 && exp_e2 < 15) exp_e2++;
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check_val({tag, "_addr"}, 32'(mem_addr), 32'd0);
      check_val({tag, "_wr_en"}, 32'(mem_wr_en), 32'd0);
      check_val({tag, "_wr_data"}, 32'(mem_wr_data), 32'd0);
      check_val({tag, "_err1"}, 32'(err1_cnt), 32'd0);
      check_val({tag, "_err2"}, 32'(err2_cnt), 32'd0);
      check_val({tag, "_done"}, 32'(done), 32'd0);
   endtask

   // Start a run at edge 0 and watch 150 cycles. Cycle c lies between edges
   // c-1 and c; inputs set mid-cycle c are sampled at edge c.
   task automatic run_words(input int reset_at, input int restart_at, input string name);
      int  done_cyc = 0;
      int  n_wr = 0;
      int  exp_wr = 0;
      wr_t e;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      for (int cyc = 1; cyc <= 150; cyc++) begin
         @(negedge clk);
         start = (cyc == restart_at);
         reset = (cyc == reset_at);
         if (cyc == 1) begin
            check_val({name, "_c1_addr"}, 32'(mem_addr), 32'(IN_BASE));
            check_val({name, "_c1_done"}, 32'(done), 32'd0);
            check_val({name, "_c1_err1"}, 32'(err1_cnt), 32'd0);
            check_val({name, "_c1_err2"}, 32'(err2_cnt), 32'd0);
         end
         if (reset_at != 0 && cyc == reset_at + 1)
            check_reset_vals({name, "_abort"});
         if (mem_wr_en) begin
            n_wr++;
            if (exp_q.size() == 0) begin
               check_val({name, "_extra_write_cycle"}, 32'(cyc), 32'd0);
            end else begin
               e = exp_q.pop_front();
               $display("%s wr cyc=%0d addr=%0d data=%02h (exp cyc=%0d addr=%0d data=%02h)",
                        name, cyc, mem_addr, mem_wr_data, e.cyc, e.addr, e.data);
               check_val({name, "_wr_cyc"}, 32'(cyc), 32'(e.cyc));
               check_val({name, "_wr_addr"}, 32'(mem_addr), 32'(e.addr));
               check_val({name, "_wr_data"}, 32'(mem_wr_data), 32'(e.data));
            end
         end
         if (done && done_cyc == 0)
            done_cyc = cyc;
      end
      start = 1'b0;
      reset = 1'b0;
      if (reset_at == 0) begin
         check_val({name, "_done_cyc"}, 32'(done_cyc), 32'(6*NW + 1));
         check_val({name, "_done_hold"}, 32'(done), 32'd1);
         check_val({name, "_err1"}, 32'(err1_cnt), 32'(exp_e1));
         check_val({name, "_err2"}, 32'(err2_cnt), 32'(exp_e2));
         check_val({name, "_n_wr"}, 32'(n_wr), 32'(2*NW));
         check_val({name, "_q_left"}, 32'(exp_q.size()), 32'd0);
      end else begin
         for (int i = 0; i < NW; i++) begin
            if (5 + 6*i <= reset_at) exp_wr++;
            if (6 + 6*i <= reset_at) exp_wr++;
         end
         check_val({name, "_done_cyc"}, 32'(done_cyc), 32'd0);
         check_val({name, "_done"}, 32'(done), 32'd0);
         check_val({name, "_n_wr"}, 32'(n_wr), 32'(exp_wr));
         exp_q.delete();
      end
   endtask

   logic [7:0] plan_a [10];
   logic [10:0] msg;
   int          b1;
   int          b2;

   initial begin
      plan_a = '{8'h01, 8'h00, 8'h01, 8'h40, 8'h01, 8'h40, 8'h11, 8'h80, 8'hFF, 8'h07};

      // Power-on reset
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals("reset");
      reset = 1'b0;

      // Run A: test-plan words followed by random clean/single/double words
      words[0] = 16'h000F;
      words[1] = 16'h020F;
      words[2] = 16'h000E;
      words[3] = 16'h021F;
      words[4] = 16'hFFFF;
      for (int i = 5; i < NW; i++) begin
         msg = 11'($urandom_range(0, 2047));
         words[i] = encode(msg);
         b1 = $urandom_range(0, 15);
         b2 = (b1 + $urandom_range(1, 15)) % 16;
         case (i % 3)
            1: words[i] = words[i] ^ (16'h0001 << b1);
            2: words[i] = words[i] ^ (16'h0001 << b1) ^ (16'h0001 << b2);
            default: ;
         endcase
      end
      load_run();
      run_words(0, 0, "A");
      for (int i = 0; i < 10; i++)
         check_val($sformatf("A_plan_byte%0d", i), 32'(out_mem[OUT_BASE + i]), 32'(plan_a[i]));

      // Run B: single flip swept over bits 1..15 on walking-one messages
      for (int i = 0; i < NW; i++) begin
         msg = 11'(1) << (i % 11);
         words[i] = encode(msg) ^ (16'h0001 << (i + 1));
      end
      load_run();
      run_words(0, 0, "B");
      check_val("B_err1_all", 32'(err1_cnt), 32'd15);

      // Run C: all-ones words, one flip each, with a start pulse mid-run
      for (int i = 0; i < NW; i++)
         words[i] = 16'hFFFF ^ (16'h0001 << i);
      load_run();
      run_words(0, 40, "C");
      check_val("C_err1_all", 32'(err1_cnt), 32'd15);
      for (int i = 0; i < NW; i++)
         check_val($sformatf("C_hi%0d", i), 32'(out_mem[OUT_BASE + 2*i + 1]), 32'h47);

      // Run E: restart from DONE with clean words; counters must clear
      for (int i = 0; i < NW; i++)
         words[i] = encode(11'($urandom_range(0, 2047)));
      load_run();
      run_words(0, 0, "E");

      // Run D: reset asserted at cycle 20 aborts the run
      for (int i = 0; i < NW; i++)
         words[i] = encode(11'($urandom_range(0, 2047))) ^ (16'h0001 << (i % 16));
      load_run();
      run_words(20, 0, "D");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
